// File: rtl/fib_sequencer.sv
// Free-running Fibonacci term generator: steps F(0)..F(N-1), one term per clock,
// then parks on the last term until the next reset.
module fib_sequencer #(
  parameter int N     = 10,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] fib_out,
  output logic [5:0]       fib_idx,
  output logic             done
);

  typedef enum logic {
    RUN,
    HOLD
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'(N - 1);

  state_t           state;
  logic [WIDTH-1:0] nxt;

  // fib_out is the cur register; nxt may wrap past the last term but is never exposed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      fib_out <= '0;
      nxt     <= WIDTH'(1);
      fib_idx <= '0;
      done    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (fib_idx == LAST_IDX) begin
            // Only reachable with N==1, where the first term is already the last.
            state <= HOLD;
            done  <= 1'b1;
          end else begin
            fib_out <= nxt;
            nxt     <= fib_out + nxt;
            fib_idx <= fib_idx + 6'd1;
            if (fib_idx + 6'd1 == LAST_IDX) begin
              state <= HOLD;
              done  <= 1'b1;
            end
          end
        end
        HOLD: begin
          done <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_sequencer.sv
// Scoreboard bench: three sequencers (N=10, N=1, N=48) share clock and reset;
// expected terms are queued before each edge and compared just after it.
module tb_fib_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] out_a, out_b, out_c;
  logic [5:0]  idx_a, idx_b, idx_c;
  logic        done_a, done_b, done_c;

  int total = 0;
  int bad   = 0;
  int k     = 0;

  typedef struct {
    int          inst;
    logic [31:0] val;
    logic [5:0]  idx;
    logic        done;
  } exp_t;

  exp_t sb[$];

  fib_sequencer #(.N(10), .WIDTH(32)) dut_a (
    .clk(clk), .reset(reset), .fib_out(out_a), .fib_idx(idx_a), .done(done_a)
  );
  fib_sequencer #(.N(1), .WIDTH(32)) dut_b (
    .clk(clk), .reset(reset), .fib_out(out_b), .fib_idx(idx_b), .done(done_b)
  );
  fib_sequencer #(.N(48), .WIDTH(32)) dut_c (
    .clk(clk), .reset(reset), .fib_out(out_c), .fib_idx(idx_c), .done(done_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] fib(input int n);
    logic [63:0] a, b, t;
    a = 64'd0;
    b = 64'd1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference behaviour after k edges since reset release.
  task automatic pushExpected(input int inst, input int n, input int kk);
    exp_t e;
    int   i;
    i      = (kk < n - 1) ? kk : n - 1;
    e.inst = inst;
    e.val  = 32'(fib(i));
    e.idx  = 6'(i);
    e.done = (kk >= n - 1) && (kk >= 1);
    sb.push_back(e);
  endtask

  task automatic popAndCompare(input string phase);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.inst)
        0: begin
          checkOutput({phase, " a.out"},  64'(out_a),  64'(e.val));
          checkOutput({phase, " a.idx"},  64'(idx_a),  64'(e.idx));
          checkOutput({phase, " a.done"}, 64'(done_a), 64'(e.done));
        end
        1: begin
          checkOutput({phase, " b.out"},  64'(out_b),  64'(e.val));
          checkOutput({phase, " b.idx"},  64'(idx_b),  64'(e.idx));
          checkOutput({phase, " b.done"}, 64'(done_b), 64'(e.done));
        end
        default: begin
          checkOutput({phase, " c.out"},  64'(out_c),  64'(e.val));
          checkOutput({phase, " c.idx"},  64'(idx_c),  64'(e.idx));
          checkOutput({phase, " c.done"}, 64'(done_c), 64'(e.done));
        end
      endcase
    end
  endtask

  task automatic checkAllZero(input string phase);
    checkOutput({phase, " a.out"}, 64'(out_a), 64'd0);
    checkOutput({phase, " a.idx"}, 64'(idx_a), 64'd0);
    checkOutput({phase, " a.done"}, 64'(done_a), 64'd0);
    checkOutput({phase, " b.out"}, 64'(out_b), 64'd0);
    checkOutput({phase, " b.done"}, 64'(done_b), 64'd0);
    checkOutput({phase, " c.out"}, 64'(out_c), 64'd0);
    checkOutput({phase, " c.idx"}, 64'(idx_c), 64'd0);
    checkOutput({phase, " c.done"}, 64'(done_c), 64'd0);
  endtask

  // Queue expectations for the next edge, take the edge, then compare.
  task automatic applyStimulus(input string phase);
    pushExpected(0, 10, k + 1);
    pushExpected(1, 1,  k + 1);
    pushExpected(2, 48, k + 1);
    @(posedge clk);
    #1;
    k++;
    popAndCompare(phase);
  endtask

  initial begin
    reset = 1'b0;
    #1;
    checkAllZero("reset");

    // Reset held across many edges: nothing may count.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checkAllZero("reset_hold");
    end

    @(negedge clk);
    reset = 1'b1;
    k = 0;
    #1;
    pushExpected(0, 10, 0);
    pushExpected(1, 1,  0);
    pushExpected(2, 48, 0);
    popAndCompare("release");

    // Covers the N=10 run, 20+ edges of hold, and the full N=48 run.
    for (int i = 0; i < 60; i++) applyStimulus("run");
    checkOutput("final48", 64'(out_c), 64'hB11924E1);
    checkOutput("final10", 64'(out_a), 64'd34);

    // Restart, then reset asynchronously between edges while the N=10 output reads 8.
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkAllZero("reset2");
    @(negedge clk);
    reset = 1'b1;
    k = 0;
    for (int i = 0; i < 6; i++) applyStimulus("pre_mid");
    checkOutput("mid_at8", 64'(out_a), 64'd8);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkAllZero("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    k = 0;
    for (int i = 0; i < 4; i++) applyStimulus("restart");
    checkOutput("restart_term", 64'(out_a), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
